ov7670_cam_emu: RTL and testbench
=================================

OV7670_CAM_EMU -- requirements
Module: ov7670_cam_emu

Purpose: synthesizable OV7670 pixel-bus transmitter that drives pclk/vsync/href/d into ov7670_capture for camera-less bring-up and bench loopback.

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports named clk and rst; the polarity and synchronicity are fixed.
REQ-002 Parameters SHALL be: c_img_cols, default 320, active pixels per line.
REQ-003 c_img_rows, default 240, active lines per frame.
REQ-004 c_pclk_half, default 2, clk cycles per pclk half-period (minimum 1).
REQ-005 c_hblank, default 16, pclk cycles href low after each line.
REQ-006 c_vsync_lines, default 3, line periods with vsync high.
REQ-007 c_vback_lines, default 17, blank line periods after vsync.
REQ-008 c_vfront_lines, default 10, blank line periods after the active region.
REQ-009 Ports SHALL be: clk in 1, system clock (100 MHz).
REQ-010 rst in 1, asynchronous active-low reset.
REQ-011 enable in 1, start or continue frame generation.
REQ-012 rgbmode in 1, 1 = RGB565 bytes, 0 = YUV422 bytes; sampled at frame start.
REQ-013 pclk out 1, generated pixel clock.
REQ-014 vsync out 1, frame sync, active high.
REQ-015 href out 1, line-valid, active high.
REQ-016 d out 8, pixel byte.
REQ-017 frame_cnt out 8, count of completed frames.
REQ-018 frame_done out 1, one-clk pulse at the end of each frame.

Function
REQ-019 pclk SHALL toggle every c_pclk_half clk cycles while not IDLE, and SHALL be held low in IDLE.
REQ-020 vsync, href and d SHALL change only on the clk cycle in which pclk falls; they SHALL be stable across every pclk rising edge.
REQ-021 A line period SHALL be 2*c_img_cols + c_hblank pclk cycles; href SHALL be high for the first 2*c_img_cols cycles, and only in ACTIVE lines.
REQ-022 The state machine SHALL have states IDLE, VSYNC, VBACK, ACTIVE and VFRONT.
REQ-023 Transitions: IDLE->VSYNC on enable=1; VSYNC->VBACK after c_vsync_lines lines; VBACK->ACTIVE after c_vback_lines lines; ACTIVE->VFRONT after c_img_rows lines; VFRONT->VSYNC if enable=1, else VFRONT->IDLE.
REQ-024 vsync SHALL be high exactly during VSYNC, i.e. c_vsync_lines*(2*c_img_cols+c_hblank) pclk cycles.
REQ-025 Deasserting enable mid-frame SHALL NOT truncate the frame; the current frame completes and the block then enters IDLE.
REQ-026 rgbmode SHALL be latched on the IDLE->VSYNC and VFRONT->VSYNC transitions; changes mid-frame SHALL take effect at the next frame.
REQ-027 Pixel col and row counters SHALL be zero-based within the active region.
REQ-028 RGB565 pixel fields: R5 = col[7:3], G6 = row[7:2], B5 = frame_cnt[4:0].
REQ-029 RGB565 byte order: byte 0 = {R5,G6[5:3]}, byte 1 = {G6[2:0],B5}.
REQ-030 YUV422 byte order per pixel pair SHALL be U, Y(col even), V, Y(col odd), with Y = col[7:0] and U = V = 8'h80; c_img_cols SHALL be even.
REQ-031 d SHALL be 8'h00 whenever href is low.
REQ-032 frame_done SHALL pulse for one clk on leaving VFRONT; frame_cnt SHALL increment in that same cycle and wrap from 255 to 0.

Reset
REQ-033 While rst=0: state = IDLE; pclk, vsync, href and frame_done = 0; d = 8'h00; frame_cnt = 0; all internal counters = 0.
REQ-034 A reset asserted mid-frame SHALL force the reset values immediately; after release the block SHALL restart from IDLE with no partial frame.

Verification
REQ-035 Use c_img_cols=4, c_img_rows=2, c_pclk_half=2, c_hblank=2, c_vsync_lines=1, c_vback_lines=1, c_vfront_lines=1, enable=1, rgbmode=1 -> pclk period 4 clk; vsync high 10 pclk; href high 8 pclk per active line; exactly 2 href pulses per frame.
REQ-036 Same setup, row 0, col 1, frame_cnt=0 -> bytes 8'h00, 8'h00; row 1 matches the REQ-028 fields; capture model sampling d on pclk rising edges reconstructs every pixel.
REQ-037 rgbmode=0 -> each line is 80 00 80 01, then 80 02 80 03; d = 00 during hblank.
REQ-038 Drop enable during ACTIVE of frame 0 -> frame completes, frame_done pulses once, frame_cnt = 1, then IDLE with pclk low.
REQ-039 Assert rst for 3 clk mid-line -> all outputs at reset values within the same cycle; after release with enable=1, the next vsync rise begins a full frame.
REQ-040 Run 256 frames -> frame_cnt wraps to 0 and frame_done pulses exactly 256 times.

Source files
------------

// File: rtl/ov7670_cam_emu.sv
// OV7670 pixel-bus emulator: drives pclk/vsync/href/d like the sensor so the
// capture path can be brought up without a camera.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | pclk parked low, all bus outputs low, waiting for enable
// S_VSYNC  | vsync high for c_vsync_lines line periods
// S_VBACK  | blank line periods after vsync
// S_ACTIVE | c_img_rows lines, href high for the first 2*c_img_cols pclks
// S_VFRONT | blank line periods; frame ends when this state is left
module ov7670_cam_emu #(
  parameter int c_img_cols     = 320,
  parameter int c_img_rows     = 240,
  parameter int c_pclk_half    = 2,
  parameter int c_hblank       = 16,
  parameter int c_vsync_lines  = 3,
  parameter int c_vback_lines  = 17,
  parameter int c_vfront_lines = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       rgbmode,
  output logic       pclk,
  output logic       vsync,
  output logic       href,
  output logic [7:0] d,
  output logic [7:0] frame_cnt,
  output logic       frame_done
);

  localparam int c_line_len = 2 * c_img_cols + c_hblank;
  localparam int c_div_w    = (c_pclk_half > 1) ? $clog2(c_pclk_half) : 1;
  localparam int c_cnt_w    = 16;
  localparam logic [c_div_w-1:0] c_div_reload = c_div_w'(c_pclk_half - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_VFRONT
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [c_div_w-1:0]   r_div;
  logic [c_cnt_w-1:0]   r_pos, w_pos_nxt;
  logic [c_cnt_w-1:0]   r_line, w_line_nxt;
  logic [c_cnt_w-1:0]   w_lines_in_state;
  logic [7:0]           r_fcnt, w_fcnt_nxt;
  logic                 r_rgb, w_rgb_nxt;
  logic                 r_pclk, r_vsync, r_href, r_done;
  logic [7:0]           r_d;
  logic                 w_fall, w_start, w_done_nxt;
  logic                 w_vsync_nxt, w_href_nxt;
  logic [7:0]           w_d_nxt, w_col, w_row, w_byte;

  // Everything on the bus moves only on the clk edge where pclk falls, so
  // the receiver always sees stable data at its rising-edge sample point.
  assign w_start = (r_state == S_IDLE) && enable;
  assign w_fall  = (r_state != S_IDLE) && r_pclk && (r_div == '0);

  // Number of line periods spent in the current state.
  always_comb begin
    w_lines_in_state = c_cnt_w'(1);
    case (r_state)
      S_VSYNC:  w_lines_in_state = c_cnt_w'(c_vsync_lines);
      S_VBACK:  w_lines_in_state = c_cnt_w'(c_vback_lines);
      S_ACTIVE: w_lines_in_state = c_cnt_w'(c_img_rows);
      S_VFRONT: w_lines_in_state = c_cnt_w'(c_vfront_lines);
      default:  w_lines_in_state = c_cnt_w'(1);
    endcase
  end

  // Next-state, position counters, frame counter and rgbmode latch.
  always_comb begin
    w_state_nxt = r_state;
    w_pos_nxt   = r_pos;
    w_line_nxt  = r_line;
    w_fcnt_nxt  = r_fcnt;
    w_rgb_nxt   = r_rgb;
    w_done_nxt  = 1'b0;
    if (w_start) begin
      w_state_nxt = S_VSYNC;
      w_pos_nxt   = '0;
      w_line_nxt  = '0;
      w_rgb_nxt   = rgbmode;
    end else if (w_fall) begin
      if (r_pos != c_cnt_w'(c_line_len - 1)) begin
        w_pos_nxt = r_pos + c_cnt_w'(1);
      end else begin
        w_pos_nxt = '0;
        if (r_line != w_lines_in_state - c_cnt_w'(1)) begin
          w_line_nxt = r_line + c_cnt_w'(1);
        end else begin
          w_line_nxt = '0;
          case (r_state)
            S_VSYNC:  w_state_nxt = S_VBACK;
            S_VBACK:  w_state_nxt = S_ACTIVE;
            S_ACTIVE: w_state_nxt = S_VFRONT;
            S_VFRONT: begin
              // enable is only looked at here, so a frame is never cut short
              w_done_nxt = 1'b1;
              w_fcnt_nxt = r_fcnt + 8'd1;
              if (enable) begin
                w_state_nxt = S_VSYNC;
                w_rgb_nxt   = rgbmode;
              end else begin
                w_state_nxt = S_IDLE;
              end
            end
            default:  w_state_nxt = S_IDLE;
          endcase
        end
      end
    end
  end

  // Bus values for the pclk period that starts at this fall.
  always_comb begin
    w_col       = w_pos_nxt[8:1];
    w_row       = w_line_nxt[7:0];
    w_vsync_nxt = (w_state_nxt == S_VSYNC);
    w_href_nxt  = (w_state_nxt == S_ACTIVE) &&
                  (w_pos_nxt < c_cnt_w'(2 * c_img_cols));
    if (w_rgb_nxt) begin
      w_byte = w_pos_nxt[0] ? {w_row[4:2], w_fcnt_nxt[4:0]}
                            : {w_col[7:3], w_row[7:5]};
    end else begin
      w_byte = w_pos_nxt[0] ? w_col : 8'h80;
    end
    w_d_nxt = w_href_nxt ? w_byte : 8'h00;
  end

  // FSM state and counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_pos   <= '0;
      r_line  <= '0;
      r_fcnt  <= '0;
      r_rgb   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pos   <= w_pos_nxt;
      r_line  <= w_line_nxt;
      r_fcnt  <= w_fcnt_nxt;
      r_rgb   <= w_rgb_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // pclk divider: down-counter reloads and toggles pclk on terminal count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div  <= '0;
      r_pclk <= 1'b0;
    end else if (w_start) begin
      r_div  <= c_div_reload;
      r_pclk <= 1'b0;
    end else if (r_state != S_IDLE) begin
      if (w_state_nxt == S_IDLE) begin
        r_div  <= '0;
        r_pclk <= 1'b0;
      end else if (r_div == '0) begin
        r_div  <= c_div_reload;
        r_pclk <= ~r_pclk;
      end else begin
        r_div  <= r_div - c_div_w'(1);
      end
    end
  end

  // Registered bus outputs, updated at frame start and on pclk falls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vsync <= 1'b0;
      r_href  <= 1'b0;
      r_d     <= 8'h00;
    end else if (w_start || w_fall) begin
      r_vsync <= w_vsync_nxt;
      r_href  <= w_href_nxt;
      r_d     <= w_d_nxt;
    end
  end

  assign pclk       = r_pclk;
  assign vsync      = r_vsync;
  assign href       = r_href;
  assign d          = r_d;
  assign frame_cnt  = r_fcnt;
  assign frame_done = r_done;

endmodule

// File: tb/tb_ov7670_cam_emu.sv
// Bench for ov7670_cam_emu: a frame-position model predicts vsync/href/d and
// frame_cnt at every pclk rising edge, plus directed scenarios.
module tb_ov7670_cam_emu;

  localparam int COLS = 4;
  localparam int ROWS = 2;
  localparam int HALF = 2;
  localparam int HB   = 2;
  localparam int VS   = 1;
  localparam int VB   = 1;
  localparam int VF   = 1;
  localparam int L    = 2 * COLS + HB;
  localparam int FR   = L * (VS + VB + ROWS + VF);
  localparam int FRAME_CLK = FR * 2 * HALF;

  logic       clk = 1'b0;
  logic       rst, enable, rgbmode;
  logic       pclk, vsync, href, frame_done;
  logic [7:0] d, frame_cnt;

  ov7670_cam_emu #(
    .c_img_cols(COLS), .c_img_rows(ROWS), .c_pclk_half(HALF), .c_hblank(HB),
    .c_vsync_lines(VS), .c_vback_lines(VB), .c_vfront_lines(VF)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .rgbmode(rgbmode),
    .pclk(pclk), .vsync(vsync), .href(href), .d(d),
    .frame_cnt(frame_cnt), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", nm, act, exp, $time);
  endtask

  // Expected {vsync, href, d} for pclk period kk of a frame.
  function automatic logic [9:0] model(input int kk, input logic rgb, input logic [7:0] fc);
    int line, p, row, col;
    logic [15:0] px;
    logic [7:0] md;
    logic mv, mh;
    line = kk / L;
    p    = kk % L;
    mv   = (line < VS);
    mh   = (line >= VS + VB) && (line < VS + VB + ROWS) && (p < 2 * COLS);
    md   = 8'h00;
    if (mh) begin
      row = line - VS - VB;
      col = p / 2;
      if (rgb) begin
        px = {5'(col >> 3), 6'(row >> 2), fc[4:0]};
        md = (p % 2 == 0) ? px[15:8] : px[7:0];
      end else begin
        md = (p % 2 == 1) ? 8'(col) : 8'h80;
      end
    end
    return {mv, mh, md};
  endfunction

  // Model state
  int         m_k = 0;
  int         m_frames = 0;
  logic [7:0] m_fcnt = 0;
  logic       m_rgb = 1'b1;
  int         done_cnt = 0;
  int         rise_cnt = 0;
  int         gap = 0;
  int         vs_hi, href_hi, href_pulses;
  logic       prev_pclk = 0, prev_done = 0, pv = 0, ph = 0, prev_href_r = 0;
  logic [7:0] pd = 0;
  logic [7:0] cap [0:L-1];
  logic [7:0] last_cap [0:L-1];
  logic [9:0] e;

  always @(negedge clk) begin
    if (!rst) begin
      m_k = 0; m_frames = 0; m_fcnt = 0; done_cnt = 0; gap = 0;
    end else begin
      gap++;
      if (frame_done) begin
        chk("done_width", prev_done, 0);
        done_cnt++;
        chk("done_vs_frames", done_cnt, m_frames);
      end
      if (pclk && !prev_pclk) begin
        rise_cnt++;
        chk("stable_vsync", vsync, pv);
        chk("stable_href", href, ph);
        chk("stable_d", d, pd);
        if (m_k == 0) begin
          m_rgb = rgbmode;
          vs_hi = 0; href_hi = 0; href_pulses = 0; prev_href_r = 0;
        end else begin
          chk("pclk_period", gap, 2 * HALF);
        end
        e = model(m_k, m_rgb, m_fcnt);
        chk("vsync", vsync, e[9]);
        chk("href", href, e[8]);
        chk("d", d, e[7:0]);
        chk("frame_cnt", frame_cnt, m_fcnt);
        vs_hi += vsync;
        href_hi += href;
        if (href && !prev_href_r) href_pulses++;
        prev_href_r = href;
        if (m_k >= (VS + VB) * L && m_k < (VS + VB + 1) * L) cap[m_k - (VS + VB) * L] = d;
        gap = 0;
        m_k++;
        if (m_k == FR) begin
          chk("vsync_pclks", vs_hi, 10);
          chk("href_pclks", href_hi, 16);
          chk("href_pulses", href_pulses, 2);
          for (int i = 0; i < L; i++) last_cap[i] = cap[i];
          m_k = 0;
          m_fcnt++;
          m_frames++;
        end
      end
    end
    prev_pclk = pclk; prev_done = frame_done; pv = vsync; ph = href; pd = d;
  end

  task automatic wait_frames(input int n);
    int target;
    target = m_frames + n;
    for (int i = 0; i < n * FRAME_CLK + 600 && m_frames < target; i++) begin
      @(posedge clk); #1;
    end
    chk("wait_frames_timeout", int'(m_frames >= target), 1);
  endtask

  task automatic wait_k(input int kmin);
    for (int i = 0; i < FRAME_CLK + 100 && m_k < kmin; i++) begin
      @(posedge clk); #1;
    end
    chk("wait_k_timeout", int'(m_k >= kmin), 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pclk"}, pclk, 0);
    chk({tag, "_vsync"}, vsync, 0);
    chk({tag, "_href"}, href, 0);
    chk({tag, "_d"}, d, 0);
    chk({tag, "_frame_cnt"}, frame_cnt, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
  endtask

  logic [7:0] exp_rgb [0:L-1];
  logic [7:0] exp_yuv [0:L-1];
  int rises0;

  initial begin
    exp_rgb = '{8'h00, 8'h02, 8'h00, 8'h02, 8'h00, 8'h02, 8'h00, 8'h02, 8'h00, 8'h00};
    exp_yuv = '{8'h80, 8'h00, 8'h80, 8'h01, 8'h80, 8'h02, 8'h80, 8'h03, 8'h00, 8'h00};
    rst = 1'b0; enable = 1'b0; rgbmode = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk_reset_vals("reset");
    @(posedge clk); #1 rst = 1'b1;
    repeat (10) @(posedge clk);
    #1 chk("idle_pclk", pclk, 0);
    chk("idle_vsync", vsync, 0);

    // Drop enable in the active region of frame 0
    enable = 1'b1;
    wait_k(25);
    enable = 1'b0;
    wait_frames(1);
    repeat (4) @(posedge clk); #1;
    chk("drop_frame_cnt", frame_cnt, 1);
    chk("drop_done_cnt", done_cnt, 1);
    rises0 = rise_cnt;
    repeat (50) @(posedge clk); #1;
    chk("drop_idle_pclk", pclk, 0);
    chk("drop_idle_vsync", vsync, 0);
    chk("drop_idle_href", href, 0);
    chk("drop_idle_rises", rise_cnt, rises0);
    chk("drop_idle_done_cnt", done_cnt, 1);

    // RGB frames, then rgbmode flipped mid-frame
    enable = 1'b1; rgbmode = 1'b1;
    wait_frames(1);
    wait_k(25);
    rgbmode = 1'b0;
    wait_frames(1);
    for (int i = 0; i < L; i++) chk("rgb_line_fc2", last_cap[i], exp_rgb[i]);
    wait_frames(1);
    for (int i = 0; i < L; i++) chk("yuv_line", last_cap[i], exp_yuv[i]);

    // Reset mid-line
    wait_k(23);
    rgbmode = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    #1 chk_reset_vals("midrst");
    repeat (3) @(posedge clk);
    #1 chk_reset_vals("midrst_hold");
    rst = 1'b1;

    // 256 frames from reset, frame_cnt wraps
    wait_frames(255);
    wait_k(20);
    enable = 1'b0;
    wait_frames(1);
    repeat (4) @(posedge clk); #1;
    chk("wrap_frame_cnt", frame_cnt, 0);
    chk("wrap_done_cnt", done_cnt, 256);
    repeat (20) @(posedge clk); #1;
    chk("wrap_idle_pclk", pclk, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
